// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the byte-wide RAM port arbiter and its clients:
// instruction fetch, load/store stage, branch flush and the RAM itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [31:0]           if_data_o;
  logic                  if_done_o;
  logic                  mem_req_i;
  logic                  mem_we_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [1:0]            mem_len_i;
  logic [31:0]           mem_wdata_i;
  logic [31:0]           mem_rdata_o;
  logic                  mem_done_o;
  logic                  ex_b_flag_i;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [7:0]            ram_dout_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_din_i;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_len_i,
           mem_wdata_i, ex_b_flag_i, ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
           ram_addr_o, ram_dout_o, ram_wr_o
  );

  // Requester / RAM side.
  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_len_i,
           mem_wdata_i, ex_b_flag_i, ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
           ram_addr_o, ram_dout_o, ram_wr_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the load/store
// stage. Multi-byte transfers are sequenced one byte per cycle, reads are
// assembled little-endian, and a taken branch aborts an in-flight fetch.
// The grant cycle itself drives the first RAM address, so the RAM-side
// outputs are combinational; done pulses and data outputs are registered.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  // Byte count for a MEM length code; code 2 is widened to a full word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    len_to_n = 3'd1;
      2'd1:    len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  // Extract little-endian byte idx of a word.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = w[7:0];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[31:24];
    endcase
  endfunction

  // Replace little-endian byte idx of a word.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    put_byte = w;
    case (idx)
      2'd0:    put_byte[7:0]   = b;
      2'd1:    put_byte[15:8]  = b;
      2'd2:    put_byte[23:16] = b;
      default: put_byte[31:24] = b;
    endcase
  endfunction

  state_t                state_r, state_s;
  logic [2:0]            k_r, k_s;
  logic [2:0]            n_r, n_s;
  logic [ADDR_WIDTH-1:0] base_r, base_s;
  logic [31:0]           wdata_r, wdata_s;
  logic [31:0]           asm_r, asm_s;
  logic [31:0]           if_data_r, if_data_s;
  logic [31:0]           mem_rdata_r, mem_rdata_s;
  logic                  if_done_r, if_done_s;
  logic                  mem_done_r, mem_done_s;
  logic [ADDR_WIDTH-1:0] addr_last_r;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [7:0]            ram_dout_s;
  logic                  ram_wr_s;
  logic                  grant_ok_s;
  logic [2:0]            km1_s;
  logic [31:0]           asm_cap_s;

  // A grant is blocked during reset and in the dead cycle of a done pulse.
  assign grant_ok_s = !rst && !(if_done_r || mem_done_r);
  // Byte slot being captured: ram_din_i in cycle k belongs to address k-1.
  assign km1_s      = k_r - 3'd1;
  assign asm_cap_s  = put_byte(asm_r, km1_s[1:0], bus.ram_din_i);

  // Next-state, RAM port drive and completion logic.
  always_comb begin
    state_s     = state_r;
    k_s         = k_r;
    n_s         = n_r;
    base_s      = base_r;
    wdata_s     = wdata_r;
    asm_s       = asm_r;
    if_data_s   = if_data_r;
    mem_rdata_s = mem_rdata_r;
    if_done_s   = 1'b0;
    mem_done_s  = 1'b0;
    ram_addr_s  = addr_last_r;
    ram_dout_s  = 8'h00;
    ram_wr_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (grant_ok_s && bus.mem_req_i) begin
          base_s     = bus.mem_addr_i;
          wdata_s    = bus.mem_wdata_i;
          n_s        = len_to_n(bus.mem_len_i);
          asm_s      = 32'h0000_0000;
          ram_addr_s = bus.mem_addr_i;
          if (bus.mem_we_i) begin
            ram_wr_s   = 1'b1;
            ram_dout_s = bus.mem_wdata_i[7:0];
            if (len_to_n(bus.mem_len_i) == 3'd1) begin
              // Single-byte store finishes in the grant cycle.
              state_s    = IDLE;
              k_s        = 3'd0;
              mem_done_s = 1'b1;
            end else begin
              state_s = MEM_WR;
              k_s     = 3'd1;
            end
          end else begin
            state_s = MEM_RD;
            k_s     = 3'd1;
          end
        end else if (grant_ok_s && bus.if_req_i && !bus.ex_b_flag_i) begin
          base_s     = bus.if_addr_i;
          n_s        = 3'd4;
          asm_s      = 32'h0000_0000;
          ram_addr_s = bus.if_addr_i;
          state_s    = IF_RD;
          k_s        = 3'd1;
        end else begin
          state_s = IDLE;
        end
      end

      IF_RD, MEM_RD: begin
        if (k_r < n_r) begin
          ram_addr_s = base_r + ADDR_WIDTH'(k_r);
        end else begin
          ram_addr_s = addr_last_r;
        end
        if ((state_r == IF_RD) && bus.ex_b_flag_i) begin
          // Taken branch: drop the fetch and everything still in flight.
          state_s = IDLE;
          k_s     = 3'd0;
        end else begin
          asm_s = asm_cap_s;
          if (k_r == n_r) begin
            state_s = IDLE;
            k_s     = 3'd0;
            if (state_r == IF_RD) begin
              if_data_s = asm_cap_s;
              if_done_s = 1'b1;
            end else begin
              mem_rdata_s = asm_cap_s;
              mem_done_s  = 1'b1;
            end
          end else begin
            k_s = k_r + 3'd1;
          end
        end
      end

      MEM_WR: begin
        ram_addr_s = base_r + ADDR_WIDTH'(k_r);
        ram_wr_s   = 1'b1;
        ram_dout_s = byte_of(wdata_r, k_r[1:0]);
        if (k_r == (n_r - 3'd1)) begin
          state_s    = IDLE;
          k_s        = 3'd0;
          mem_done_s = 1'b1;
        end else begin
          k_s = k_r + 3'd1;
        end
      end

      default: begin
        state_s = IDLE;
        k_s     = 3'd0;
      end
    endcase
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= 3'd0;
      n_r         <= 3'd0;
      base_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      asm_r       <= 32'h0000_0000;
      if_data_r   <= 32'h0000_0000;
      mem_rdata_r <= 32'h0000_0000;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      addr_last_r <= '0;
    end else begin
      state_r     <= state_s;
      k_r         <= k_s;
      n_r         <= n_s;
      base_r      <= base_s;
      wdata_r     <= wdata_s;
      asm_r       <= asm_s;
      if_data_r   <= if_data_s;
      mem_rdata_r <= mem_rdata_s;
      if_done_r   <= if_done_s;
      mem_done_r  <= mem_done_s;
      addr_last_r <= ram_addr_s;
    end
  end

  assign bus.if_data_o   = if_data_r;
  assign bus.if_done_o   = if_done_r;
  assign bus.mem_rdata_o = mem_rdata_r;
  assign bus.mem_done_o  = mem_done_r;
  assign bus.ram_addr_o  = ram_addr_s;
  assign bus.ram_dout_o  = ram_dout_s;
  assign bus.ram_wr_o    = ram_wr_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte RAM model with one-cycle read
// latency, fetch, contention, store, byte load, branch flush, reset mid-store.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic        pl_we;
  logic [10:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  ram [0:2047];

  mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte RAM: write on DUT strobe (or bench preload), read data one cycle later.
  always @(posedge clk) begin
    if (bus.ram_wr_o) ram[bus.ram_addr_o[10:0]] <= bus.ram_dout_o;
    else if (pl_we)   ram[pl_addr] <= pl_data;
    bus.ram_din_i <= ram[bus.ram_addr_o[10:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic poke(input logic [10:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    to_cycle();
    pl_we = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; pl_we = 1'b0; pl_addr = 11'd0; pl_data = 8'd0;
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'd0;
    bus.mem_len_i = 2'd0; bus.mem_wdata_i = 32'd0; bus.ex_b_flag_i = 1'b0;
    #1 rst = 1'b1;

    // Preload while reset is held.
    to_cycle();
    poke(11'h100, 8'h13); poke(11'h101, 8'h05); poke(11'h102, 8'h10); poke(11'h103, 8'h00);
    poke(11'h104, 8'hB3); poke(11'h105, 8'h02); poke(11'h106, 8'h31); poke(11'h107, 8'h00);
    poke(11'h200, 8'h78); poke(11'h201, 8'h56); poke(11'h202, 8'h34); poke(11'h203, 8'h12);
    poke(11'h010, 8'hF0); poke(11'h011, 8'hAB);
    poke(11'h401, 8'h5A); poke(11'h402, 8'h02); poke(11'h403, 8'h01);
    poke(11'h301, 8'h66);

    mid();
    chk("rst_if_data",   bus.if_data_o, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata_o, 32'h0);
    chk("rst_ram_wr",    {31'd0, bus.ram_wr_o}, 32'h0);
    chk("rst_ram_addr",  bus.ram_addr_o, 32'h0);
    chk("rst_if_done",   {31'd0, bus.if_done_o}, 32'h0);
    chk("rst_mem_done",  {31'd0, bus.mem_done_o}, 32'h0);
    to_cycle();
    rst = 1'b0;

    // Fetch from 0x100.
    to_cycle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    mid();
    chk("fetch_addr0", bus.ram_addr_o, 32'h100);
    chk("fetch_wr0", {31'd0, bus.ram_wr_o}, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      to_cycle();
      mid();
      if (c <= 3) chk("fetch_addr", bus.ram_addr_o, 32'h100 + c);
      else        chk("fetch_addr_hold", bus.ram_addr_o, 32'h103);
      chk("fetch_done", {31'd0, bus.if_done_o}, (c == 5) ? 32'd1 : 32'd0);
    end
    chk("fetch_data", bus.if_data_o, 32'h0010_0513);
    to_cycle();
    bus.if_req_i = 1'b0;
    mid();
    chk("fetch_done_single", {31'd0, bus.if_done_o}, 32'h0);
    chk("fetch_data_hold", bus.if_data_o, 32'h0010_0513);

    // Contention: MEM load wins, IF follows after the dead cycle.
    to_cycle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'd3; bus.mem_addr_i = 32'h200;
    mid();
    chk("cont_addr0", bus.ram_addr_o, 32'h200);
    for (int c = 1; c <= 5; c++) begin
      to_cycle();
      mid();
      chk("cont_mem_done", {31'd0, bus.mem_done_o}, (c == 5) ? 32'd1 : 32'd0);
      chk("cont_if_done", {31'd0, bus.if_done_o}, 32'd0);
    end
    chk("cont_rdata", bus.mem_rdata_o, 32'h1234_5678);
    chk("cont_nogrant_addr", bus.ram_addr_o, 32'h203);
    to_cycle();
    bus.mem_req_i = 1'b0;
    mid();
    chk("cont_if_grant", bus.ram_addr_o, 32'h104);
    for (int c = 7; c <= 11; c++) begin
      to_cycle();
      mid();
      chk("cont_if_done2", {31'd0, bus.if_done_o}, (c == 11) ? 32'd1 : 32'd0);
      chk("cont_mem_done2", {31'd0, bus.mem_done_o}, 32'd0);
    end
    chk("cont_if_data", bus.if_data_o, 32'h0031_02B3);
    to_cycle();
    bus.if_req_i = 1'b0;

    // Two-byte store across 0x3FF/0x400; inputs scrambled after grant.
    to_cycle();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'd1;
    bus.mem_addr_i = 32'h3FF; bus.mem_wdata_i = 32'hAABB_CCDD;
    mid();
    chk("st_wr0", {31'd0, bus.ram_wr_o}, 32'd1);
    chk("st_addr0", bus.ram_addr_o, 32'h3FF);
    chk("st_dout0", {24'd0, bus.ram_dout_o}, 32'hDD);
    to_cycle();
    bus.mem_addr_i = 32'h0; bus.mem_wdata_i = 32'h0;
    mid();
    chk("st_wr1", {31'd0, bus.ram_wr_o}, 32'd1);
    chk("st_addr1", bus.ram_addr_o, 32'h400);
    chk("st_dout1", {24'd0, bus.ram_dout_o}, 32'hCC);
    chk("st_done1", {31'd0, bus.mem_done_o}, 32'd0);
    to_cycle();
    mid();
    chk("st_wr2", {31'd0, bus.ram_wr_o}, 32'd0);
    chk("st_done2", {31'd0, bus.mem_done_o}, 32'd1);
    to_cycle();
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
    mid();
    chk("st_ram3ff", {24'd0, ram[11'h3FF]}, 32'hDD);
    chk("st_ram400", {24'd0, ram[11'h400]}, 32'hCC);
    chk("st_ram401", {24'd0, ram[11'h401]}, 32'h5A);

    // Byte load from 0x10.
    to_cycle();
    bus.mem_req_i = 1'b1; bus.mem_len_i = 2'd0; bus.mem_addr_i = 32'h10;
    mid();
    chk("bl_addr0", bus.ram_addr_o, 32'h10);
    to_cycle();
    mid();
    chk("bl_done1", {31'd0, bus.mem_done_o}, 32'd0);
    to_cycle();
    mid();
    chk("bl_done2", {31'd0, bus.mem_done_o}, 32'd1);
    chk("bl_rdata", bus.mem_rdata_o, 32'h0000_00F0);
    to_cycle();
    bus.mem_req_i = 1'b0;

    // Flush: branch in cycle 2 of a fetch, new fetch to 0x400 from cycle 3.
    to_cycle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    to_cycle();
    to_cycle();
    bus.ex_b_flag_i = 1'b1; bus.if_addr_i = 32'h400;
    to_cycle();
    bus.ex_b_flag_i = 1'b0;
    mid();
    chk("fl_grant_addr", bus.ram_addr_o, 32'h400);
    for (int c = 3; c <= 8; c++) begin
      if (c > 3) begin
        to_cycle();
        mid();
      end
      chk("fl_if_done", {31'd0, bus.if_done_o}, (c == 8) ? 32'd1 : 32'd0);
      chk("fl_if_data", bus.if_data_o, (c == 8) ? 32'h0102_5ACC : 32'h0031_02B3);
    end
    to_cycle();
    bus.if_req_i = 1'b0;

    // Reset asserted in cycle 1 of a 4-byte store.
    to_cycle();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'd3;
    bus.mem_addr_i = 32'h300; bus.mem_wdata_i = 32'h1122_3344;
    mid();
    chk("rs_wr0", {31'd0, bus.ram_wr_o}, 32'd1);
    to_cycle();
    #1;
    chk("rs_wr1_pre", {31'd0, bus.ram_wr_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_wr_fall", {31'd0, bus.ram_wr_o}, 32'd0);
    chk("rs_addr_clr", bus.ram_addr_o, 32'd0);
    to_cycle();
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
    mid();
    chk("rs_done_c2", {31'd0, bus.mem_done_o}, 32'd0);
    to_cycle();
    rst = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      mid();
      chk("rs_no_done", {31'd0, bus.mem_done_o}, 32'd0);
      to_cycle();
    end
    chk("rs_ram300", {24'd0, ram[11'h300]}, 32'h44);
    chk("rs_ram301", {24'd0, ram[11'h301]}, 32'h66);
    chk("rs_rdata_clr", bus.mem_rdata_o, 32'd0);
    bus.mem_req_i = 1'b1; bus.mem_len_i = 2'd0; bus.mem_addr_i = 32'h10;
    mid();
    chk("rs_regrant_addr", bus.ram_addr_o, 32'h10);
    to_cycle();
    mid();
    chk("rs_regrant_done1", {31'd0, bus.mem_done_o}, 32'd0);
    to_cycle();
    mid();
    chk("rs_regrant_done2", {31'd0, bus.mem_done_o}, 32'd1);
    chk("rs_regrant_rdata", bus.mem_rdata_o, 32'h0000_00F0);
    to_cycle();
    bus.mem_req_i = 1'b0;
    to_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Sequences multi-byte transfers one byte per cycle and assembles little-endian words.
- Signals completion to each requester, which feeds the stall logic driving the IF/ID register.
- Aborts in-flight fetches on a taken branch.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_i  in  1  IF requests a 4-byte instruction fetch.
- if_addr_i  in  ADDR_WIDTH  fetch byte address.
- if_data_o  out  32  assembled instruction.
- if_done_o  out  1  one-cycle fetch-complete pulse.
- mem_req_i  in  1  MEM requests a load/store.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  ADDR_WIDTH  data byte address.
- mem_len_i  in  2  byte count minus 1: 0 = 1B, 1 = 2B, 3 = 4B; value 2 is treated as 4B.
- mem_wdata_i  in  32  store data; byte k = bits [8k+7:8k].
- mem_rdata_o  out  32  load data, zero-extended.
- mem_done_o  out  1  one-cycle load/store-complete pulse.
- ex_b_flag_i  in  1  taken branch from EX; flushes a fetch.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_dout_o  out  8  RAM write byte.
- ram_wr_o  out  1  RAM write enable.
- ram_din_i  in  8  RAM read byte; valid one cycle after its address is presented.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE, byte counter to 0.
  - All outputs go to 0, including ram_wr_o, if_data_o and mem_rdata_o.
  - Reset during an active transfer drops it with no done pulse.
- States are IDLE, IF_RD, MEM_RD and MEM_WR, with a 3-bit counter k. N = 4 for IF; N = mem_len_i + 1 for MEM, except len 2 gives N = 4.
- IDLE grant:
  - mem_req_i has priority over if_req_i.
  - IF is not granted in a cycle where ex_b_flag_i = 1.
  - No grant occurs in a cycle where if_done_o or mem_done_o is high. This guarantees one dead cycle so requesters can drop req.
  - Address, length, we and wdata are latched at grant. Later input changes are ignored.
- Read (IF_RD, MEM_RD):
  - The grant cycle is cycle 0. In cycle k (0..N-1), ram_addr_o = base + k and ram_wr_o = 0.
  - In cycle k (1..N), ram_din_i is captured into byte k-1 of an assembly register.
  - After cycle N the state returns to IDLE. Done is registered and pulses in cycle N+1 with the data output updated that same cycle.
  - Fetch latency from grant to if_done_o is 5 cycles. A 1-byte load takes 2 cycles.
  - Unfilled upper bytes are 0.
- Write (MEM_WR):
  - In cycle k (0..N-1), ram_addr_o = base + k, ram_dout_o = wdata byte k, ram_wr_o = 1.
  - The state returns to IDLE after cycle N-1, and mem_done_o pulses in cycle N.
- Addresses: base + k wraps modulo 2^ADDR_WIDTH.
- Idle outputs: ram_wr_o = 0 and ram_addr_o holds its last value.
- Data outputs: if_data_o and mem_rdata_o change only when their respective done pulses and hold otherwise.
- Flush:
  - ex_b_flag_i = 1 in any IF_RD cycle ends the fetch: next state is IDLE and there is no if_done_o.
  - Bytes in flight are discarded and if_data_o is unchanged.
  - The IDLE cycle following the abort may grant normally.
  - MEM transactions are never aborted.
- Each done is a single-cycle pulse. The two done outputs are never high together.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00; if_req_i from cycle 0 → reads addresses 0x100..0x103 in cycles 0..3; if_done_o in cycle 5 with if_data_o = 0x00100513.
- Contention: if_req_i and mem_req_i (load, len = 3, addr 0x200, RAM = 78,56,34,12) both high in cycle 0 → mem_done_o in cycle 5 with mem_rdata_o = 0x12345678; no grant in cycle 5; IF granted in cycle 6; if_done_o in cycle 11.
- Store: mem_we_i = 1, len = 1, addr 0x3FF, wdata 0xAABBCCDD → ram_wr_o high for 2 cycles writing 0xDD@0x3FF then 0xCC@0x400; mem_done_o in cycle 2; RAM[0x401] unchanged.
- Byte load: len = 0, addr 0x10, RAM = 0xF0 → mem_rdata_o = 0x000000F0 in cycle 2.
- Flush: ex_b_flag_i pulsed in cycle 2 of a fetch → no if_done_o; if_data_o unchanged; a new fetch to 0x400 granted in cycle 3 completes in cycle 8.
- Reset mid-store: rst asserted asynchronously in cycle 1 of a 4-byte store → ram_wr_o falls immediately; no mem_done_o; after release, a new request is granted normally.
